// File: rtl/alarm_zone_ctrl.sv
// Zone alarm controller: passcode arm/disarm, synchronised sensor edges, entry delay.
// Optional wrong-code lockout is compiled in by defining ALARM_LOCKOUT_EN.
module alarm_zone_ctrl #(
  parameter int                CODE_W       = 10,
  parameter int                N_ZONES      = 4,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(10'h112),
  parameter int                ENTRY_CYCLES = 50_000_000,
  parameter int                MAX_TRIES    = 3,
  parameter int                LOCK_CYCLES  = 250_000_000
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [CODE_W-1:0]  iCode,
  input  logic               iCode_Load,
  input  logic               iCode_Submit,
  input  logic               iArm,
  input  logic [N_ZONES-1:0] iSense,
  input  logic [N_ZONES-1:0] iZone_Mask,
  output logic               oArmed,
  output logic               oVideo_On,
  output logic               oAlarm,
  output logic               oLockout,
  output logic [2:0]         oState,
  output logic [N_ZONES-1:0] oZone_Latched
);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_ENTRY    = 3'd2,
    ST_ALARM    = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  localparam int CNT_MAX = (ENTRY_CYCLES > LOCK_CYCLES) ? ENTRY_CYCLES : LOCK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD  = CNT_W'(LOCK_CYCLES - 1);

  if (ENTRY_CYCLES < 1 || LOCK_CYCLES < 1 || MAX_TRIES < 1) begin : g_param_check
    $error("alarm_zone_ctrl: ENTRY_CYCLES, LOCK_CYCLES and MAX_TRIES must be >= 1");
  end

  state_t             r_state;
  logic [2:0]         r_flags;  // {armed, video, alarm}
  logic [CODE_W-1:0]  r_code;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_ZONES-1:0] r_s1, r_s2, r_prev, r_latched;
  logic [N_ZONES-1:0] w_hit;
  logic               w_match, w_good, w_expired, w_trip;

  assign w_hit     = (r_s2 ^ r_prev) & iZone_Mask;
  assign w_match   = (iCode == r_code);
  assign w_good    = iCode_Submit & w_match;
  assign w_expired = (r_cnt == '0);

  function automatic logic [2:0] f_flags(input state_t s);
    case (s)
      ST_ARMED:   f_flags = 3'b100;
      ST_ENTRY:   f_flags = 3'b110;
      ST_ALARM:   f_flags = 3'b111;
      ST_LOCKOUT: f_flags = 3'b111;
      default:    f_flags = 3'b000;
    endcase
  endfunction

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= ST_DISARMED;
      r_flags   <= '0;
      r_code    <= DEFAULT_CODE;
      r_cnt     <= '0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_prev    <= '0;
      r_latched <= '0;
    end else begin
      // r_prev always follows the synchronised level, so arming restarts edge detection cleanly
      r_s1   <= iSense;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (r_state != ST_DISARMED) r_latched <= r_latched | w_hit;
      if ((r_state == ST_ENTRY || r_state == ST_LOCKOUT) && !w_expired) r_cnt <= r_cnt - 1'b1;

      case (r_state)
        ST_DISARMED: begin
          if (iCode_Load) begin
            r_code <= iCode;
          end else if (iArm) begin
            r_state   <= ST_ARMED;
            r_flags   <= f_flags(ST_ARMED);
            r_latched <= '0;
          end
        end
        ST_ARMED, ST_ENTRY, ST_ALARM: begin
          // A correct code beats both a lockout trip and entry-delay expiry
          if (w_good) begin
            r_state <= ST_DISARMED;
            r_flags <= f_flags(ST_DISARMED);
          end else if (w_trip) begin
            r_state <= ST_LOCKOUT;
            r_flags <= f_flags(ST_LOCKOUT);
            r_cnt   <= LOCK_LD;
          end else if (r_state == ST_ARMED && |w_hit) begin
            r_state <= ST_ENTRY;
            r_flags <= f_flags(ST_ENTRY);
            r_cnt   <= ENTRY_LD;
          end else if (r_state == ST_ENTRY && w_expired) begin
            r_state <= ST_ALARM;
            r_flags <= f_flags(ST_ALARM);
          end
        end
`ifdef ALARM_LOCKOUT_EN
        ST_LOCKOUT: begin
          if (w_expired) begin
            r_state <= ST_ALARM;
            r_flags <= f_flags(ST_ALARM);
          end
        end
`endif
        default: begin
          r_state <= ST_DISARMED;
          r_flags <= f_flags(ST_DISARMED);
        end
      endcase
    end
  end

`ifdef ALARM_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);

  logic [FAIL_W-1:0] r_fail;
  logic [FAIL_W-1:0] w_fail_inc;
  logic              w_active, w_wrong, r_lockout;

  assign w_active   = (r_state == ST_ARMED) || (r_state == ST_ENTRY) || (r_state == ST_ALARM);
  assign w_wrong    = w_active & iCode_Submit & ~w_match;
  assign w_fail_inc = (r_fail == {FAIL_W{1'b1}}) ? r_fail : r_fail + 1'b1;
  assign w_trip     = w_wrong & (w_fail_inc >= FAIL_W'(MAX_TRIES));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_fail    <= '0;
      r_lockout <= 1'b0;
    end else begin
      if (w_active) begin
        if (w_good || w_trip) r_fail <= '0;
        else if (w_wrong)     r_fail <= w_fail_inc;
      end
      // Tracks entry to and exit from ST_LOCKOUT alongside the FSM
      if (w_trip)                                      r_lockout <= 1'b1;
      else if (r_state == ST_LOCKOUT && w_expired)     r_lockout <= 1'b0;
      else if (r_state != ST_LOCKOUT)                  r_lockout <= 1'b0;
    end
  end

  assign oLockout = r_lockout;
`else
  assign w_trip   = 1'b0;
  assign oLockout = 1'b0;
`endif

  assign {oArmed, oVideo_On, oAlarm} = r_flags;
  assign oState        = r_state;
  assign oZone_Latched = r_latched;

endmodule

// File: doc/alarm_zone_ctrl.md
ALARM_ZONE_CTRL -- requirements
Module: alarm_zone_ctrl

Interface
REQ-001 SHALL provide parameter CODE_W, default 10, passcode width in bits.
REQ-002 SHALL provide parameter N_ZONES, default 4, number of sensor zones.
REQ-003 SHALL provide parameter DEFAULT_CODE, default 10'h112, passcode loaded at reset.
REQ-004 SHALL provide parameter ENTRY_CYCLES, default 50_000_000, entry-delay length in iCLK cycles (>=1).
REQ-005 SHALL provide parameter MAX_TRIES, default 3, wrong submits before lockout (>=1).
REQ-006 SHALL provide parameter LOCK_CYCLES, default 250_000_000, lockout length in iCLK cycles (>=1).
REQ-007 SHALL have port iCLK, input, 1, the single system clock; all logic on its rising edge.
REQ-008 SHALL have port iRST, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have port iCode, input, CODE_W, switch passcode value.
REQ-010 SHALL have port iCode_Load, input, 1, one-cycle pulse storing iCode as the new passcode.
REQ-011 SHALL have port iCode_Submit, input, 1, one-cycle pulse comparing iCode with the stored passcode.
REQ-012 SHALL have port iArm, input, 1, one-cycle arm request.
REQ-013 SHALL have port iSense, input, N_ZONES, asynchronous raw sensor levels.
REQ-014 SHALL have port iZone_Mask, input, N_ZONES, 1 = zone enabled.
REQ-015 SHALL have ports oArmed, oVideo_On, oAlarm, oLockout, output, 1 each, state flags, and oState, output, 3, the state encoding.
REQ-016 SHALL have port oZone_Latched, output, N_ZONES, zones that have tripped since the last arm.

Function
REQ-017 SHALL synchronise each iSense bit through two flops, then keep a third "previous" flop; edge = sync XOR previous, either polarity.
REQ-018 SHALL implement states DISARMED=0, ARMED=1, ENTRY=2, ALARM=3, LOCKOUT=4, with no other reachable encodings.
REQ-019 DISARMED: iCode_Load stores iCode; iArm goes to ARMED next cycle, clears oZone_Latched, and resets the previous flops to the current sync values; iCode_Load wins if both pulse together.
REQ-020 iCode_Load SHALL be ignored in every state other than DISARMED.
REQ-021 ARMED: any edge AND iZone_Mask goes to ENTRY and loads the counter with ENTRY_CYCLES-1.
REQ-022 ENTRY: the counter decrements each cycle; expiry at 0 goes to ALARM.
REQ-023 In ARMED/ENTRY/ALARM, a correct submit goes to DISARMED and clears the fail counter.
REQ-024 Correct submit and counter expiry in the same cycle SHALL resolve to DISARMED.
REQ-025 Masked edges SHALL also be ignored for latching; unmasked edges in ARMED, ENTRY, ALARM or LOCKOUT OR into oZone_Latched in the same cycle the state updates.
REQ-026 Outputs SHALL be registered:
- oArmed=1 in ARMED/ENTRY/ALARM/LOCKOUT;
- oVideo_On=1 in ENTRY/ALARM/LOCKOUT;
- oAlarm=1 in ALARM/LOCKOUT;
- oLockout=1 in LOCKOUT.
REQ-027 The counter SHALL be $clog2(max(ENTRY_CYCLES,LOCK_CYCLES)+1) bits wide and never wrap below 0.
REQ-028 iArm in any state other than DISARMED SHALL be ignored.

Reset
REQ-029 On iRST: state=DISARMED, passcode=DEFAULT_CODE, counter=0, fail count=0, sync/previous flops=0, oZone_Latched=0, all flag outputs=0, oState=0.
REQ-030 iRST mid-ENTRY or mid-LOCKOUT SHALL abort immediately; there is no state retention.

Configuration
REQ-031 With ALARM_LOCKOUT_EN defined:
- a wrong submit in ARMED/ENTRY/ALARM increments the fail counter (saturating);
- reaching MAX_TRIES goes to LOCKOUT, loads the counter with LOCK_CYCLES-1, and clears the fail count;
- in LOCKOUT all submits are ignored; on expiry go to ALARM.
REQ-032 Without ALARM_LOCKOUT_EN: wrong submits have no effect, LOCKOUT is unreachable, oLockout is constant 0, and no fail counter exists.

Verification (ENTRY_CYCLES=8, LOCK_CYCLES=16, MAX_TRIES=3, N_ZONES=4, mask=4'hF)
REQ-033 Reset, then submit 10'h112 -> state stays DISARMED, all flags 0; load 10'h2A5, then submit 10'h2A5 in ARMED -> DISARMED.
REQ-034 Arm, then toggle iSense[2] -> oZone_Latched=4'b0100, ENTRY at sync+1 cycle; no submit -> ALARM exactly 8 cycles after entering ENTRY.
REQ-035 In ENTRY, a correct submit on the expiry cycle -> DISARMED, oAlarm never asserts.
REQ-036 Mask=4'b1011, toggle iSense[2] while ARMED -> stays ARMED, oZone_Latched=0.
REQ-037 ALARM_LOCKOUT_EN: 3 wrong submits in ALARM -> LOCKOUT; a correct submit during lockout is ignored; after 16 cycles -> ALARM; then a correct submit -> DISARMED.
REQ-038 Assert iRST during LOCKOUT -> next cycle DISARMED, passcode=10'h112, all outputs 0.
